hc194_seq_ctrl: RTL

- Command sequencer directly upstream of the 4-bit universal shift register stage (74HC194 function).
- Accepts LOAD/CLEAR/SHIFT/ROTATE commands over a valid/ready handshake.
- Drives the register's mode select S[1:0], parallel D, DSR and DSL for the required number of CP cycles.
- Reads back the register's Q so rotates can be closed externally.

---
 rtl/hc194_seq_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/hc194_seq_ctrl.sv
// Command sequencer that drives a 74HC194-style 4-bit universal shift register.
// Optional readback checker: define HC194_SEQ_CTRL_CHECK_EN.
//
// state | meaning
// IDLE  | ready for a command, shift register held
// RUN   | mode of latched op on s_out, rem cycles remaining
// DONE  | one-cycle completion pulse, shift register held
module hc194_seq_ctrl #(
    parameter int CNT_W = 4
) (
    input  logic             CP,
    input  logic             MR,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [0:3]       cmd_data,
    input  logic             cmd_fill,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [0:3]       q_in,
    output logic [1:0]       s_out,
    output logic [0:3]       d_out,
    output logic             dsr_out,
    output logic             dsl_out,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_SHR   = 3'b001;
    localparam logic [2:0] OP_SHL   = 3'b010;
    localparam logic [2:0] OP_ROR   = 3'b011;
    localparam logic [2:0] OP_ROL   = 3'b100;
    localparam logic [2:0] OP_CLEAR = 3'b101;

    state_t           state_q, state_nx;
    logic [2:0]       op_q, op_nx;
    logic [0:3]       data_q, data_nx;
    logic             fill_q, fill_nx;
    logic [CNT_W-1:0] rem_q, rem_nx;
    logic [1:0]       s_q, s_nx;
    logic [0:3]       d_q, d_nx;
    logic             dsr_q, dsr_nx;
    logic             dsl_q, dsl_nx;

    always_comb begin
        state_nx = state_q;
        op_nx    = op_q;
        data_nx  = data_q;
        fill_nx  = fill_q;
        rem_nx   = rem_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_nx   = cmd_op;
                    data_nx = cmd_data;
                    fill_nx = cmd_fill;
                    case (cmd_op)
                        OP_LOAD, OP_CLEAR: begin
                            rem_nx   = CNT_W'(1);
                            state_nx = RUN;
                        end
                        OP_SHR, OP_SHL, OP_ROR, OP_ROL: begin
                            rem_nx   = cmd_cnt;
                            state_nx = (cmd_cnt == '0) ? DONE : RUN;
                        end
                        default: begin
                            rem_nx   = '0;
                            state_nx = DONE;
                        end
                    endcase
                end
            end
            RUN: begin
                rem_nx = rem_q - 1'b1;
                if (rem_q == CNT_W'(1)) state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase

        // Mode outputs are registered, so they are decoded from the next state.
        s_nx   = 2'b00;
        d_nx   = 4'b0000;
        dsr_nx = 1'b0;
        dsl_nx = 1'b0;
        if (state_nx == RUN) begin
            case (op_nx)
                OP_LOAD: begin
                    s_nx = 2'b11;
                    d_nx = data_nx;
                end
                OP_CLEAR: s_nx = 2'b11;
                OP_SHR: begin
                    s_nx   = 2'b01;
                    dsr_nx = fill_nx;
                end
                OP_SHL: begin
                    s_nx   = 2'b10;
                    dsl_nx = fill_nx;
                end
                OP_ROR:  s_nx = 2'b01;
                OP_ROL:  s_nx = 2'b10;
                default: s_nx = 2'b00;
            endcase
        end
    end

    always_ff @(posedge CP) begin
        if (MR) begin
            state_q <= IDLE;
            op_q    <= '0;
            data_q  <= '0;
            fill_q  <= 1'b0;
            rem_q   <= '0;
            s_q     <= 2'b00;
            d_q     <= '0;
            dsr_q   <= 1'b0;
            dsl_q   <= 1'b0;
        end else begin
            state_q <= state_nx;
            op_q    <= op_nx;
            data_q  <= data_nx;
            fill_q  <= fill_nx;
            rem_q   <= rem_nx;
            s_q     <= s_nx;
            d_q     <= d_nx;
            dsr_q   <= dsr_nx;
            dsl_q   <= dsl_nx;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign s_out     = s_q;
    assign d_out     = d_q;
    // Rotates close the loop through the live Q, so these paths stay combinational.
    assign dsr_out   = (state_q == RUN && op_q == OP_ROR) ? q_in[3] : dsr_q;
    assign dsl_out   = (state_q == RUN && op_q == OP_ROL) ? q_in[0] : dsl_q;

`ifdef HC194_SEQ_CTRL_CHECK_EN
    logic [0:3] model_q;
    logic       err_q;

    always_ff @(posedge CP) begin
        if (MR) begin
            model_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state_q == RUN) begin
                case (s_q)
                    2'b11: model_q <= d_q;
                    2'b01: model_q <= {((op_q == OP_ROR) ? model_q[3] : dsr_q), model_q[0:2]};
                    2'b10: model_q <= {model_q[1:3], ((op_q == OP_ROL) ? model_q[0] : dsl_q)};
                    default: model_q <= model_q;
                endcase
            end
            if (state_q == DONE && q_in != model_q) err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
